// File: rtl/ahfp_pkg.sv
// Shared types and helpers for the ahfp floating-point blocks.
// Width-derived constants are functions so parameterised modules can reuse them.
package ahfp_pkg;

  typedef enum logic [1:0] {ClsNorm, ClsZero, ClsInf, ClsNan} fp_class_e;

  typedef enum logic [1:0] {StIdle, StMul, StFin} state_e;

  function automatic int unsigned bias_of(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned exp_max_of(input int unsigned exp_w);
    return (32'd1 << exp_w) - 32'd1;
  endfunction

  localparam int unsigned DefExpW = 8;
  localparam int unsigned DefManW = 23;
  localparam int unsigned BIAS    = bias_of(DefExpW);
  localparam int unsigned EXP_MAX = exp_max_of(DefExpW);
  localparam logic [DefExpW+DefManW:0] QNAN =
      {1'b0, {DefExpW{1'b1}}, 1'b1, {(DefManW-1){1'b0}}};

  // Operands are passed zero-extended; exp_w gives the real exponent width.
  function automatic fp_class_e fp_class(input logic [31:0] exp, input logic [63:0] frac,
                                         input int unsigned exp_w);
    logic [31:0] ones;
    ones = exp_max_of(exp_w);
    if (exp == 32'd0) return ClsZero;
    if (exp == ones) return (frac != 64'd0) ? ClsNan : ClsInf;
    return ClsNorm;
  endfunction

endpackage

// File: rtl/ahfp_norm_round.sv
// Normalise, round-to-nearest-even and pack a raw significand product,
// applying special-class, overflow and flush-to-zero results.
module ahfp_norm_round
  import ahfp_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                     sign,
  input  logic signed [EXP_W+1:0]  exponent,
  input  logic [2*MAN_W+1:0]       prod,
  input  fp_class_e                cls,
  output logic [EXP_W+MAN_W:0]     result
);

  localparam int unsigned SW = MAN_W + 1;
  localparam int unsigned PW = 2 * SW;
  localparam logic signed [EXP_W+1:0] ExpMaxS = (EXP_W+2)'(exp_max_of(EXP_W));

  logic [PW-1:0]            norm;
  logic [MAN_W-1:0]         frac;
  logic [MAN_W-1:0]         frac_r;
  logic                     guard;
  logic                     sticky;
  logic                     round_up;
  logic [SW:0]              sum;
  logic signed [EXP_W+1:0]  exp_n;
  logic signed [EXP_W+1:0]  exp_r;
  logic                     ovf;
  logic                     unf;
  logic                     unused_bits;

  always_comb begin
    norm     = prod[PW-1] ? prod : {prod[PW-2:0], 1'b0};
    exp_n    = exponent + (EXP_W+2)'(prod[PW-1]);
    frac     = norm[PW-2 -: MAN_W];
    guard    = norm[SW-1];
    sticky   = |norm[SW-2:0];
    round_up = guard & (sticky | frac[0]);
    sum      = {2'b01, frac} + (SW+1)'(round_up);
    // A carry out of rounding means the significand became exactly 2.0.
    exp_r    = exp_n + (EXP_W+2)'(sum[SW]);
    frac_r   = sum[SW] ? '0 : sum[MAN_W-1:0];
    ovf      = !exp_r[EXP_W+1] && (exp_r >= ExpMaxS);
    unf      = exp_r[EXP_W+1] || (exp_r == '0);

    if (cls == ClsNan) begin
      result = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    end else if (cls == ClsInf || (cls == ClsNorm && ovf)) begin
      result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cls == ClsZero || unf) begin
      result = {sign, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      result = {sign, exp_r[EXP_W-1:0], frac_r};
    end
  end

  // Hidden-bit positions are implied and never read.
  assign unused_bits = norm[PW-1] ^ sum[MAN_W];

endmodule

// File: rtl/ahfp_mult_seq.sv
// Multi-cycle radix-2^RADIX_BITS floating-point multiplier with a fixed latency
// and a clk_en/start/done handshake.
module ahfp_mult_seq
  import ahfp_pkg::*;
#(
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 23,
  parameter int unsigned RADIX_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic [EXP_W+MAN_W:0]   dataa,
  input  logic [EXP_W+MAN_W:0]   datab,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   done
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned SW    = MAN_W + 1;
  localparam int unsigned PW    = 2 * SW;
  localparam int unsigned N     = SW / RADIX_BITS;
  localparam int unsigned CNT_W = $clog2(N + 1);
  localparam int unsigned BiasW = bias_of(EXP_W);

  if (SW % RADIX_BITS != 0) begin : g_bad_radix
    $error("RADIX_BITS must divide MAN_W+1");
  end

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [PW-1:0]           mcand_q, mcand_d;
  logic [SW-1:0]           mplier_q, mplier_d;
  logic                    sign_q, sign_d;
  logic signed [EXP_W+1:0] exp_q, exp_d;
  fp_class_e               cls_q, cls_d;
  logic [W-1:0]            result_q, result_d;
  logic                    done_q, done_d;

  logic [EXP_W-1:0]        ea, eb;
  logic [MAN_W-1:0]        fa, fb;
  fp_class_e               cls_a, cls_b;
  logic [W-1:0]            nr_result;

  assign ea = dataa[W-2:MAN_W];
  assign eb = datab[W-2:MAN_W];
  assign fa = dataa[MAN_W-1:0];
  assign fb = datab[MAN_W-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    cls_d    = cls_q;
    result_d = result_q;
    done_d   = 1'b0;
    cls_a    = fp_class(32'(ea), 64'(fa), EXP_W);
    cls_b    = fp_class(32'(eb), 64'(fb), EXP_W);

    unique case (state_q)
      StIdle: begin
        // done_q marks the completion cycle; a start there is dropped.
        if (start && !done_q) begin
          state_d  = StMul;
          sign_d   = dataa[W-1] ^ datab[W-1];
          exp_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - $signed((EXP_W+2)'(BiasW));
          mcand_d  = (ea != '0) ? PW'({1'b1, fa}) : '0;
          mplier_d = (eb != '0) ? {1'b1, fb} : '0;
          acc_d    = '0;
          cnt_d    = '0;
          if (cls_a == ClsNan || cls_b == ClsNan ||
              (cls_a == ClsInf && cls_b == ClsZero) ||
              (cls_a == ClsZero && cls_b == ClsInf)) begin
            cls_d = ClsNan;
          end else if (cls_a == ClsInf || cls_b == ClsInf) begin
            cls_d = ClsInf;
          end else if (cls_a == ClsZero || cls_b == ClsZero) begin
            cls_d = ClsZero;
          end else begin
            cls_d = ClsNorm;
          end
        end
      end
      StMul: begin
        if (cnt_q == CNT_W'(N)) begin
          state_d = StFin;
        end else begin
          acc_d    = acc_q + mcand_q * PW'(mplier_q[RADIX_BITS-1:0]);
          mcand_d  = mcand_q << RADIX_BITS;
          mplier_d = mplier_q >> RADIX_BITS;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      StFin: begin
        result_d = nr_result;
        done_d   = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  ahfp_norm_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_norm_round (
    .sign     (sign_q),
    .exponent (exp_q),
    .prod     (acc_q),
    .cls      (cls_q),
    .result   (nr_result)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_q    <= ClsNorm;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cls_q    <= cls_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign result = result_q;
  assign done   = done_q;

endmodule
